// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and fills IF/ID.
// Optional taken-redirect counter is enabled by defining FETCH_REDIRECT_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_reg,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_read,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fetch_fault,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0] KIND_BRANCH   = 2'b00;
    localparam logic [1:0] KIND_JUMP     = 2'b01;
    localparam logic [1:0] KIND_REGISTER = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] if_pc_next;
    logic [31:0] if_pc4_next;
    logic        fault_next;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect_take;
    logic        jr_misaligned;
    logic        pc_out_of_range;

    assign imem_addr = pc;

    // Targets are formed from the instruction currently sitting in decode.
    assign branch_target = if_pc4 + {{14{if_instr[15]}}, if_instr[15:0], 2'b00};
    assign jump_target   = {if_pc4[31:28], if_instr[25:0], 2'b00};

    always_comb begin
        redirect_target = redirect_reg;
        case (redirect_kind)
            KIND_BRANCH:   redirect_target = branch_target;
            KIND_JUMP:     redirect_target = jump_target;
            KIND_REGISTER: redirect_target = redirect_reg;
            default:       redirect_target = redirect_reg;
        endcase
    end

    assign redirect_take   = redirect_valid && (redirect_kind != 2'b11);
    assign jr_misaligned   = redirect_valid && (redirect_kind == KIND_REGISTER)
                             && (redirect_reg[1:0] != 2'b00);
    assign pc_out_of_range = {2'b00, pc[31:2]} >= IMEM_WORDS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0;
            if_pc       <= 32'h0;
            if_pc4      <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_valid    <= valid_next;
            if_instr    <= instr_next;
            if_pc       <= if_pc_next;
            if_pc4      <= if_pc4_next;
            fetch_fault <= fault_next;
        end
    end

    // A misaligned jr outranks every other redirect; redirects outrank stall.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        valid_next  = if_valid;
        instr_next  = if_instr;
        if_pc_next  = if_pc;
        if_pc4_next = if_pc4;
        fault_next  = fetch_fault;

        case (state)
            BOOT: begin
                valid_next = 1'b0;
                state_next = RUN;
            end
            RUN: begin
                if (jr_misaligned) begin
                    state_next = HALT;
                    fault_next = 1'b1;
                    valid_next = 1'b0;
                end else if (redirect_take) begin
                    pc_next    = redirect_target;
                    valid_next = 1'b0;
                end else if (stall) begin
                    pc_next = pc;
                end else if (pc_out_of_range) begin
                    state_next = HALT;
                    fault_next = 1'b1;
                    valid_next = 1'b0;
                end else begin
                    instr_next  = imem_read;
                    if_pc_next  = pc;
                    if_pc4_next = pc + 32'd4;
                    valid_next  = 1'b1;
                    pc_next     = pc + 32'd4;
                end
            end
            HALT: begin
                valid_next = 1'b0;
                fault_next = 1'b1;
            end
            default: begin
                state_next = HALT;
                valid_next = 1'b0;
                fault_next = 1'b1;
            end
        endcase
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic        redirect_fire;
    logic [15:0] count;

    assign redirect_fire = (state == RUN) && redirect_take && !jr_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'h0;
        end else if (redirect_fire && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign redirect_count = count;
`else
    assign redirect_count = 16'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: sequential fetch, stall, redirects, faults and reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_reg;
    logic [31:0] imem_addr;
    logic [31:0] imem_read;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_fault;
    logic [15:0] redirect_count;

    logic [31:0] mem [0:19];

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [1:0]  kind;
        logic [31:0] rreg;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_fault;
    } row_t;

    row_t rows[$];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_reg   (redirect_reg),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .fetch_fault    (fetch_fault),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_read = (imem_addr[31:2] < 30'd20) ? mem[imem_addr[6:2]] : 32'hFFFF_FFFF;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_row(input logic s, input logic rv, input logic [1:0] k,
                           input logic [31:0] rr, input logic v, input logic [31:0] p,
                           input logic [31:0] p4, input logic [31:0] ins,
                           input logic [31:0] a, input logic f);
        row_t r;
        r.stall = s; r.rv = rv; r.kind = k; r.rreg = rr;
        r.e_valid = v; r.e_pc = p; r.e_pc4 = p4; r.e_instr = ins;
        r.e_addr = a; r.e_fault = f;
        rows.push_back(r);
    endtask

    // Drive one row's inputs, take one clock edge, then compare away from the edge.
    task automatic apply_stimulus(input string tag);
        foreach (rows[i]) begin
            stall          = rows[i].stall;
            redirect_valid = rows[i].rv;
            redirect_kind  = rows[i].kind;
            redirect_reg   = rows[i].rreg;
            @(posedge clk);
            #1;
            check_output($sformatf("%s%0d.if_valid", tag, i), {31'b0, if_valid}, {31'b0, rows[i].e_valid});
            check_output($sformatf("%s%0d.if_pc", tag, i), if_pc, rows[i].e_pc);
            check_output($sformatf("%s%0d.if_pc4", tag, i), if_pc4, rows[i].e_pc4);
            check_output($sformatf("%s%0d.if_instr", tag, i), if_instr, rows[i].e_instr);
            check_output($sformatf("%s%0d.imem_addr", tag, i), imem_addr, rows[i].e_addr);
            check_output($sformatf("%s%0d.fault", tag, i), {31'b0, fetch_fault}, {31'b0, rows[i].e_fault});
        end
        stall = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'b00; redirect_reg = 32'h0;
        rows.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, ".if_valid"}, {31'b0, if_valid}, 32'h0);
        check_output({tag, ".if_pc"}, if_pc, 32'h0);
        check_output({tag, ".if_pc4"}, if_pc4, 32'h0);
        check_output({tag, ".if_instr"}, if_instr, 32'h0);
        check_output({tag, ".imem_addr"}, imem_addr, 32'h0);
        check_output({tag, ".fault"}, {31'b0, fetch_fault}, 32'h0);
        check_output({tag, ".count"}, {16'b0, redirect_count}, 32'h0);
    endtask

    initial begin
        logic [15:0] exp_count;
        for (int i = 0; i < 20; i++) mem[i] = 32'h1000_0000 | i;
        mem[12] = 32'h0C00_0013;   // jal, target field 19
        mem[13] = 32'hB000_0003;   // bleu, imm 3

`ifdef FETCH_REDIRECT_CNT_EN
        exp_count = 16'd3;
`else
        exp_count = 16'd0;
`endif

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_kind = 2'b00; redirect_reg = 32'h0;
        #12;
        check_reset_state("rst0");
        reset = 1'b0;

        // Sequence A: boot, sequential fetch, stall, jal, jr, bleu+stall, kind 11, run off the end.
        add_row(0, 0, 2'b00, 0, 0, 0, 0, 0, 4, 0);
        for (int w = 0; w < 3; w++)
            add_row(0, 0, 2'b00, 0, 1, w * 4, w * 4 + 4, mem[w], w * 4 + 4, 0);
        for (int s = 0; s < 3; s++)
            add_row(1, 0, 2'b00, 0, 1, 8, 12, mem[2], 12, 0);
        for (int w = 3; w < 13; w++)
            add_row(0, 0, 2'b00, 0, 1, w * 4, w * 4 + 4, mem[w], w * 4 + 4, 0);
        add_row(0, 1, 2'b01, 0, 0, 48, 52, mem[12], 76, 0);
        add_row(0, 0, 2'b00, 0, 1, 76, 80, mem[19], 80, 0);
        add_row(0, 1, 2'b10, 52, 0, 76, 80, mem[19], 52, 0);
        add_row(0, 0, 2'b00, 0, 1, 52, 56, mem[13], 56, 0);
        add_row(1, 1, 2'b00, 0, 0, 52, 56, mem[13], 68, 0);
        add_row(0, 0, 2'b00, 0, 1, 68, 72, mem[17], 72, 0);
        add_row(0, 1, 2'b11, 0, 1, 72, 76, mem[18], 76, 0);
        add_row(0, 0, 2'b00, 0, 1, 76, 80, mem[19], 80, 0);
        add_row(0, 0, 2'b00, 0, 0, 76, 80, mem[19], 80, 1);
        add_row(0, 0, 2'b00, 0, 0, 76, 80, mem[19], 80, 1);
        add_row(0, 1, 2'b01, 0, 0, 76, 80, mem[19], 80, 1);
        // Fix up the first row: BOOT leaves the PC at 0.
        rows[0].e_addr = 0;
        apply_stimulus("A");
        check_output("A.count", {16'b0, redirect_count}, {16'b0, exp_count});

        // Asynchronous reset from HALT, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_reset_state("rst1");
        #1 reset = 1'b0;

        // Sequence B: misaligned jr freezes the stage with the fault raised.
        add_row(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 2'b00, 0, 1, 0, 4, mem[0], 4, 0);
        add_row(0, 0, 2'b00, 0, 1, 4, 8, mem[1], 8, 0);
        add_row(0, 1, 2'b10, 54, 0, 4, 8, mem[1], 8, 1);
        add_row(0, 0, 2'b00, 0, 0, 4, 8, mem[1], 8, 1);
        add_row(0, 1, 2'b10, 40, 0, 4, 8, mem[1], 8, 1);
        apply_stimulus("B");
        check_output("B.count", {16'b0, redirect_count}, 32'h0);

        #1 reset = 1'b1;
        #1;
        check_reset_state("rst2");
        #1 reset = 1'b0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-issue core. Owns the program counter and drives the word address into the combinational instruction memory.
- Registers the returned word into the IF/ID pipeline register.
- Applies redirects (bleu, j/jal, jr) resolved in decode. No delay slot: any wrong-path fetch is squashed.
- Detects fetch faults: PC beyond the memory, or a misaligned jr target.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
IMEM_WORDS, 20, number of valid instruction words; word index >= IMEM_WORDS is a fault

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high
stall  input  1  decode back-pressure; hold PC and IF/ID
redirect_valid  input  1  decode resolved a taken control transfer for the instruction in IF/ID
redirect_kind  input  2  00 branch (bleu), 01 jump (j/jal), 10 register (jr), 11 reserved (ignored)
redirect_reg  input  32  jr source register value
imem_addr  output  32  byte address to instruction memory (= PC)
imem_read  input  32  instruction word returned combinationally
if_valid  output  1  IF/ID holds a real instruction
if_instr  output  32  IF/ID instruction
if_pc  output  32  IF/ID instruction address
if_pc4  output  32  if_pc + 4; jal link value for r7
fetch_fault  output  1  sticky fault flag
redirect_count  output  16  taken-redirect counter (see Optional Feature)

Behaviour:
- Reset (asynchronous):
  - PC = RESET_PC; state = BOOT.
  - if_valid = 0; if_instr = 0; if_pc = 0; if_pc4 = 0; fetch_fault = 0; redirect_count = 0.
- imem_addr = PC, combinational. Fetch latency: one cycle from PC to IF/ID.
- Arithmetic: all PC arithmetic is 32-bit and wraps mod 2^32.
- Redirect targets are computed from the IF/ID fields, i.e. the instruction in decode:
  - branch: if_pc4 + (sign-extend(if_instr[15:0]) << 2).
  - jump: {if_pc4[31:28], if_instr[25:0], 2'b00}.
  - register: redirect_reg.
- States:
  - BOOT (exactly one cycle after reset release): if_valid stays 0; PC unchanged; go to RUN.
  - RUN: see the per-cycle priority below.
  - HALT: PC and IF/ID frozen; if_valid = 0; fetch_fault = 1. Left only by reset.
- Per-cycle priority in RUN, highest first:
  1. redirect_valid with kind 10 and redirect_reg[1:0] != 0: enter HALT, set fault, if_valid <= 0.
  2. redirect_valid with kind 00, 01 or 10:
     - PC <= target; if_valid <= 0 (squash the wrong-path word).
     - The redirect wins over a simultaneous stall.
  3. stall: PC and all IF/ID registers hold.
  4. PC word index (PC >> 2) >= IMEM_WORDS: enter HALT, set fault, if_valid <= 0.
  5. Otherwise:
     - if_instr <= imem_read; if_pc <= PC; if_pc4 <= PC + 4; if_valid <= 1.
     - PC <= PC + 4.
- redirect_kind 11 with redirect_valid: treated as no redirect; stall and normal fetch rules still apply.
- A redirect to an out-of-range address is accepted. The fault is raised on the following cycle, when rule 4 evaluates the new PC.
- if_instr, if_pc and if_pc4 keep their old values while if_valid = 0; consumers must qualify them with if_valid.
- Reset asserted mid-operation (including in HALT) returns everything to the reset values asynchronously.

Optional Feature:
- Macro: FETCH_REDIRECT_CNT_EN.
- Defined:
  - redirect_count increments by 1 on every cycle that rule 2 fires; saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: redirect_count is tied to 0 and no counter flops are synthesized.

Test Plan:
- Sequential fetch: reset, RESET_PC = 0, release.
  - BOOT cycle shows if_valid = 0.
  - Then if_pc = 0, 4, 8 on successive cycles, with if_instr = memory words 0, 1, 2 and if_pc4 = 4, 8, 12.
- Stall: assert stall for 3 cycles with if_pc = 8.
  - if_pc/if_instr hold and imem_addr stays 12.
  - After release, if_pc = 12.
- Branch: IF/ID holds the bleu at if_pc = 52 with imm 3; pulse redirect_valid, kind 00, together with stall = 1.
  - Next cycle: if_valid = 0, imem_addr = 68.
  - Following cycle: if_pc = 68.
- Jump and return:
  - jal at if_pc = 48 with target field 19, kind 01: imem_addr = 76, and if_pc4 was 52 during the redirect.
  - Later jr, kind 10, with redirect_reg = 52: imem_addr = 52.
- Faults:
  - jr with redirect_reg = 54: fetch_fault = 1 and if_valid stays 0 for all further cycles.
  - Separately, running sequentially off the end with PC = 80 and IMEM_WORDS = 20: fault set, if_pc stays 76.
  - Reset clears the fault.
- Counter (with FETCH_REDIRECT_CNT_EN): 3 redirects give redirect_count = 3; an asynchronous reset mid-run gives 0 immediately.
